// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage_if
// Description : Handshake bundle around one pipeline skid stage (both sides).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    // Stage side of the bundle
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output occupancy
    );

    // Environment side: drives upstream payload and downstream ready
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  occupancy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Two-entry registered skid buffer between pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  wire                 clk,
    input  wire                 rst_n,
    pipe_skid_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_acc;
    logic w_pop;
    logic w_main_from_in;
    logic w_main_from_skid;
    logic w_skid_from_in;

    // Handshake outputs come only from the state register
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_main;
    assign bus.occupancy = (r_state == ST_FULL) ? 2'd2 :
                           (r_state == ST_ONE)  ? 2'd1 : 2'd0;

    assign w_acc = bus.in_valid & bus.in_ready;
    assign w_pop = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (bus.flush) begin
            // Squash both entries; data registers intentionally keep stale values
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt    = ST_ONE;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_pop) begin
                        w_main_from_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt    = ST_FULL;
                        w_skid_from_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= RST_DATA;
            r_skid <= RST_DATA;
        end else begin
            if (w_main_from_in) begin
                r_main <= bus.in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= bus.in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Randomized bench for pipe_skid_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipe_skid_stage_if #(.WIDTH(W)) bus ();

    pipe_skid_stage #(
        .WIDTH    (W),
        .RST_DATA ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned      n_vec = 0;
    int unsigned      n_err = 0;
    logic [W-1:0]     model_q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare visible outputs with the model contents (called away from posedge)
    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, W'(bus.out_valid), W'(model_q.size() != 0));
        chk({tag, ".in_ready"},  W'(bus.in_ready),  W'(model_q.size() < 2));
        chk({tag, ".occupancy"}, W'(bus.occupancy), W'(model_q.size()));
        if (model_q.size() != 0)
            chk({tag, ".out_data"}, bus.out_data, model_q[0]);
    endtask

    // One cycle: check, drive at negedge, advance model, wait next negedge
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
        bit exp_rdy;
        bit acc;
        bit pop;
        check_outputs(tag);
        exp_rdy = (model_q.size() < 2);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #1;
        chk({tag, ".in_ready_indep"}, W'(bus.in_ready), W'(exp_rdy));
        acc = v && exp_rdy;
        pop = r && (model_q.size() != 0);
        if (f) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] held;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset.out_valid", W'(bus.out_valid), '0);
        chk("reset.in_ready",  W'(bus.in_ready),  W'(1));
        chk("reset.occupancy", W'(bus.occupancy), '0);
        chk("reset.out_data",  bus.out_data,      '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            step("t2", 1'b1, W'(i), 1'b1, 1'b0);
            chk("t2.data", bus.out_data, W'(i));
            chk("t2.occ",  W'(bus.occupancy), W'(1));
        end
        step("t2_drain", 1'b0, '0, 1'b1, 1'b0);

        // Backpressure fills the skid, then drains in order
        step("t3", 1'b1, 32'hA, 1'b0, 1'b0);
        step("t3", 1'b1, 32'hB, 1'b0, 1'b0);
        chk("t3.full_occ",   W'(bus.occupancy), W'(2));
        chk("t3.full_ready", W'(bus.in_ready),  '0);
        step("t3", 1'b1, 32'hC, 1'b0, 1'b0);
        chk("t3.first", bus.out_data, 32'hA);
        step("t3", 1'b1, 32'hC, 1'b1, 1'b0);
        chk("t3.second", bus.out_data, 32'hB);
        step("t3", 1'b1, 32'hC, 1'b1, 1'b0);
        chk("t3.third", bus.out_data, 32'hC);
        step("t3", 1'b0, '0, 1'b1, 1'b0);
        chk("t3.empty", W'(bus.out_valid), '0);

        // Flush while full with a new input offered
        step("t4", 1'b1, 32'h1, 1'b0, 1'b0);
        step("t4", 1'b1, 32'h2, 1'b0, 1'b0);
        step("t4", 1'b1, 32'hD, 1'b0, 1'b1);
        chk("t4.out_valid", W'(bus.out_valid), '0);
        chk("t4.in_ready",  W'(bus.in_ready),  W'(1));
        chk("t4.occupancy", W'(bus.occupancy), '0);
        step("t4", 1'b1, 32'h5, 1'b1, 1'b0);
        chk("t4.no_d", bus.out_data, 32'h5);
        step("t4", 1'b0, '0, 1'b1, 1'b0);

        // Stall hold
        step("t6", 1'b1, 32'h77, 1'b0, 1'b0);
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            step("t6", 1'b0, '0, 1'b0, 1'b0);
            chk("t6.hold", bus.out_data, held);
        end
        step("t6", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step("t5", 1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)),
                 ($urandom_range(99) == 0));
        end

        // Asynchronous reset mid-cycle while full
        bus.flush = 1'b0;
        step("t1", 1'b1, 32'hE1, 1'b0, 1'b0);
        step("t1", 1'b1, 32'hE2, 1'b0, 1'b0);
        step("t1", 1'b1, 32'hE3, 1'b0, 1'b0);
        chk("t1.pre_occ", W'(bus.occupancy), W'(2));
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("t1.out_valid", W'(bus.out_valid), '0);
        chk("t1.in_ready",  W'(bus.in_ready),  W'(1));
        chk("t1.occupancy", W'(bus.occupancy), '0);
        chk("t1.out_data",  bus.out_data,      '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step("t1_after", 1'b1, 32'h99, 1'b1, 1'b0);
        check_outputs("t1_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
